// File: rtl/snes_pad_reader.sv
// SNES gamepad poller: latches the pad, shifts in 16 serial bits and presents a
// two-poll debounced 12-bit button vector together with a pad-ID check.
module snes_pad_reader #(
  parameter int unsigned HALF_CYCLES  = 129,
  parameter int unsigned LATCH_CYCLES = 258,
  parameter int unsigned POLL_CYCLES  = 357950
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_strb,
  output logic        joy_clk,
  output logic [11:0] buttons,
  output logic        valid,
  output logic        id_ok
);

  localparam int unsigned PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned HW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] POLL_ZERO  = PW'(0);
  localparam logic [PW-1:0] POLL_ONE   = PW'(1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYCLES - 1);
  localparam logic [HW-1:0] PH_ZERO    = HW'(0);
  localparam logic [HW-1:0] PH_ONE     = HW'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [1:0]    sync_r;
  logic          data_s;
  logic [PW-1:0] poll_cnt_r;
  logic          poll_wrap_s;
  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [HW-1:0] phase_r;
  logic [HW-1:0] phase_s;
  logic [3:0]    bit_r;
  logic [3:0]    bit_s;
  logic          sample_s;
  logic          finish_s;
  logic [15:0]   raw_r;
  logic [15:0]   prev_raw_r;
  logic [11:0]   buttons_r;
  logic [11:0]   buttons_s;
  logic          id_ok_r;
  logic          id_ok_s;
  logic          joy_strb_r;
  logic          joy_clk_r;
  logic          valid_r;

  assign data_s      = sync_r[1];
  assign poll_wrap_s = (poll_cnt_r == POLL_LAST);

  // Two-flop synchronizer for the asynchronous pad data line
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], joy_data};
    end
  end

  // Free-running poll period counter; its wrap starts each latch
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt_r <= POLL_ZERO;
    end else if (poll_wrap_s) begin
      poll_cnt_r <= POLL_ZERO;
    end else begin
      poll_cnt_r <= poll_cnt_r + POLL_ONE;
    end
  end

  // Next-state logic for the latch / shift sequence
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    bit_s    = bit_r;
    sample_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (poll_wrap_s) begin
          state_s = ST_LATCH;
          phase_s = PH_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (phase_r == LATCH_LAST) begin
          state_s = ST_LOW;
          phase_s = PH_ZERO;
          bit_s   = 4'd0;
        end else begin
          phase_s = phase_r + PH_ONE;
        end
      end
      ST_LOW: begin
        if (phase_r == HALF_LAST) begin
          state_s  = ST_HIGH;
          phase_s  = PH_ZERO;
          sample_s = 1'b1;
        end else begin
          phase_s = phase_r + PH_ONE;
        end
      end
      ST_HIGH: begin
        if (phase_r == HALF_LAST) begin
          phase_s = PH_ZERO;
          if (bit_r == 4'd15) begin
            state_s  = ST_DONE;
            finish_s = 1'b1;
          end else begin
            state_s = ST_LOW;
            bit_s   = bit_r + 4'd1;
          end
        end else begin
          phase_s = phase_r + PH_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = PH_ZERO;
        bit_s   = 4'd0;
      end
    endcase
  end

  // Debounce: accept a reading only when it repeats the previous poll;
  // evaluated on entry to DONE so buttons and id_ok settle with valid
  always_comb begin
    buttons_s = buttons_r;
    id_ok_s   = id_ok_r;
    if (finish_s) begin
      id_ok_s = (raw_r[15:12] == 4'b1111);
      if (raw_r[15:12] != 4'b1111) begin
        buttons_s = 12'h000;
      end else if (raw_r == prev_raw_r) begin
        buttons_s = ~raw_r[11:0];
      end else begin
        buttons_s = buttons_r;
      end
    end else begin
      buttons_s = buttons_r;
      id_ok_s   = id_ok_r;
    end
  end

  // FSM state, shift register and registered pad-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_ZERO;
      bit_r      <= 4'd0;
      raw_r      <= 16'hFFFF;
      prev_raw_r <= 16'hFFFF;
      buttons_r  <= 12'h000;
      id_ok_r    <= 1'b0;
      joy_strb_r <= 1'b0;
      joy_clk_r  <= 1'b1;
      valid_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      bit_r   <= bit_s;
      if (sample_s) begin
        raw_r[bit_r] <= data_s;
      end
      if (finish_s) begin
        prev_raw_r <= raw_r;
      end
      buttons_r  <= buttons_s;
      id_ok_r    <= id_ok_s;
      joy_strb_r <= (state_s == ST_LATCH);
      joy_clk_r  <= (state_s != ST_LOW);
      valid_r    <= finish_s;
    end
  end

  assign joy_strb = joy_strb_r;
  assign joy_clk  = joy_clk_r;
  assign buttons  = buttons_r;
  assign valid    = valid_r;
  assign id_ok    = id_ok_r;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: pad model, expectation queue checked on every valid,
// plus pin-timing and mid-poll reset checks.
module tb_snes_pad_reader;

  localparam int HALF  = 4;
  localparam int LATCH = 8;
  localparam int POLL  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        joy_data;
  logic        joy_strb;
  logic        joy_clk;
  logic [11:0] buttons;
  logic        valid;
  logic        id_ok;

  typedef struct packed {
    logic [11:0] btn;
    logic        id;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pad_raw = 16'hFFFF;
  int          checks = 0;
  int          errors = 0;
  int          poll_no = 0;

  logic [15:0] raw_tab[$];
  logic [11:0] btn_tab[$];
  logic        id_tab[$];

  snes_pad_reader #(
    .HALF_CYCLES (HALF),
    .LATCH_CYCLES(LATCH),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .joy_data(joy_data),
    .joy_strb(joy_strb),
    .joy_clk (joy_clk),
    .buttons (buttons),
    .valid   (valid),
    .id_ok   (id_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add(input logic [15:0] raw, input logic [11:0] btn, input logic id);
    raw_tab.push_back(raw);
    btn_tab.push_back(btn);
    id_tab.push_back(id);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 2 * POLL);
    check("valid_arrives", 32'(valid), 32'd1);
  endtask

  // Pad model: strobe presents bit 0, each joy_clk rise advances one bit
  initial begin
    int idx;
    idx = 16;
    joy_data = 1'b1;
    forever begin
      @(posedge joy_strb or posedge joy_clk);
      if (joy_strb) idx = 0;
      else if (idx < 16) idx++;
      joy_data = (idx < 16) ? pad_raw[idx] : 1'b1;
    end
  end

  // Monitor: every valid pops one expectation and checks the poll period
  initial begin
    int cyc;
    int last_v;
    exp_t e;
    cyc = 0;
    last_v = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        last_v = -1;
      end else if (valid) begin
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("buttons_poll%0d", poll_no), 32'(buttons), 32'(e.btn));
          check($sformatf("id_ok_poll%0d", poll_no), 32'(id_ok), 32'(e.id));
        end
        if (last_v >= 0) check("valid_period", cyc - last_v, POLL);
        last_v = cyc;
        poll_no++;
      end
    end
  end

  // Pin timing of the first poll after reset release
  initial begin
    int n;
    int vidx;
    int lows;
    logic [7:0] pat;
    logic tr_clk[140];
    logic tr_v[140];
    @(negedge reset);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!joy_strb && n < 1000);
    check("first_strb_cycle", n, POLL);
    n = 0;
    while (joy_strb && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("strb_width", n, LATCH);
    for (int i = 0; i < 140; i++) begin
      tr_clk[i] = joy_clk;
      tr_v[i]   = valid;
      @(posedge clk);
      #1;
    end
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 8; k++) pat[k] = tr_clk[8 * p + k];
      check($sformatf("clk_pulse%0d", p), 32'(pat), 32'h0000_00F0);
    end
    lows = 0;
    for (int i = 128; i < 140; i++) if (!tr_clk[i]) lows++;
    check("no_extra_pulse", lows, 0);
    vidx = -1;
    for (int i = 139; i >= 0; i--) if (tr_v[i]) vidx = i;
    check("valid_offset", vidx, 16 * 2 * HALF);
  end

  // Stimulus: directed poll table, then reset during the 7th low pulse
  initial begin
    int n;
    int falls;
    logic prev_clk;
    logic [11:0] prev_b;
    logic [15:0] r;
    exp_t e;

    add(16'hFFFF, 12'h000, 1'b1);
    add(16'hFFFF, 12'h000, 1'b1);
    add(16'hFEF7, 12'h000, 1'b1);  // A+Start, first sighting holds
    add(16'hFEF7, 12'h108, 1'b1);
    add(16'hFFFF, 12'h108, 1'b1);
    add(16'hF6F7, 12'h108, 1'b1);  // A+Start+R
    add(16'hF6F7, 12'h908, 1'b1);
    add(16'h0FFF, 12'h000, 1'b0);  // no pad ID clears nonzero buttons
    add(16'hFEF7, 12'h000, 1'b1);
    add(16'hFFFF, 12'h000, 1'b1);
    add(16'hFEF7, 12'h000, 1'b1);
    add(16'hFFFF, 12'h000, 1'b1);
    add(16'hFFDB, 12'h000, 1'b1);  // Select+Down
    add(16'hFFDB, 12'h024, 1'b1);
    prev_b = 12'h024;
    for (int k = 0; k < 12; k++) begin
      r = 16'hFFFF ^ (16'h0001 << k);
      add(r, prev_b, 1'b1);
      add(r, 12'h001 << k, 1'b1);
      prev_b = 12'h001 << k;
    end

    repeat (3) @(negedge clk);
    check("rst_strb", 32'(joy_strb), 32'd0);
    check("rst_clk", 32'(joy_clk), 32'd1);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_id_ok", 32'(id_ok), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < raw_tab.size(); i++) begin
      pad_raw = raw_tab[i];
      e.btn = btn_tab[i];
      e.id  = id_tab[i];
      exp_q.push_back(e);
      wait_valid();
    end

    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!joy_strb && n < 2 * POLL);
    check("abort_poll_strb", 32'(joy_strb), 32'd1);
    falls = 0;
    prev_clk = joy_clk;
    n = 0;
    while (falls < 7 && n < 2 * POLL) begin
      @(posedge clk);
      #1;
      n++;
      if (prev_clk && !joy_clk) falls++;
      prev_clk = joy_clk;
    end
    check("abort_fall_count", falls, 7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_clk", 32'(joy_clk), 32'd1);
    check("abort_strb", 32'(joy_strb), 32'd0);
    check("abort_buttons", 32'(buttons), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_id_ok", 32'(id_ok), 32'd0);
    @(negedge clk);
    e.btn = 12'h000;
    e.id  = 1'b1;
    exp_q.push_back(e);
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!joy_strb && n < 1000);
    check("strb_after_reset", n, POLL);
    wait_valid();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the run stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
